// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: word-addressed data/instruction memory for the multicycle CPU.
// Every access takes a programmable number of cycles and completes with a
// one-cycle Ready pulse. Misaligned, out-of-range and conflicting (read+write)
// requests keep the same timing but complete with Err and no memory update.
module mem_wait_ctrl #(
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addr,
    input  logic [31:0] W_data,
    input  logic        MemRd,
    input  logic        MemWr,
    output logic [31:0] R_data,
    output logic        Ready,
    output logic        Err
);

    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    // Holding registers for the captured request
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic             r_wr;
    logic             r_rd;
    logic             r_err;

    logic [31:0]      r_rdata;
    logic [31:0]      r_mem [DEPTH];

    logic             w_req;
    logic             w_in_err;
    logic [CNT_W-1:0] w_in_cnt;
    logic             w_enter_done;
    logic [IDX_W-1:0] w_acc_idx;
    logic [31:0]      w_acc_wdata;
    logic             w_acc_wr;
    logic             w_acc_rd;
    logic             w_acc_err;

    // Decode the live request: latency selection and error classification.
    // A simultaneous read+write is treated as a (rejected) write for timing.
    always_comb begin
        w_req    = MemRd | MemWr;
        w_in_cnt = MemWr ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
        w_in_err = (MemRd & MemWr)
                 | (Addr[1:0] != 2'b00)
                 | ({2'b00, Addr[31:2]} >= 32'(DEPTH));
    end

    // Operands for the edge entering DONE: with a latency of 1 that edge is
    // the capture edge itself, so the live inputs are used instead of the
    // holding registers.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_acc_idx   = Addr[IDX_W+1:2];
            w_acc_wdata = W_data;
            w_acc_wr    = MemWr & ~MemRd;
            w_acc_rd    = MemRd & ~MemWr;
            w_acc_err   = w_in_err;
        end else begin
            w_acc_idx   = r_idx;
            w_acc_wdata = r_wdata;
            w_acc_wr    = r_wr;
            w_acc_rd    = r_rd;
            w_acc_err   = r_err;
        end
    end

    // Next-state logic and the strobe marking the edge that enters DONE
    always_comb begin
        w_next       = r_state;
        w_enter_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_in_cnt == '0) begin
                        w_next       = S_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next       = S_DONE;
                    w_enter_done = 1'b1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register and latency down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE:  if (w_req) r_cnt <= w_in_cnt;
                S_BUSY:  r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Capture the request in IDLE; later changes on the inputs are ignored
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_req) begin
            r_idx   <= Addr[IDX_W+1:2];
            r_wdata <= W_data;
            r_wr    <= MemWr & ~MemRd;
            r_rd    <= MemRd & ~MemWr;
            r_err   <= w_in_err;
        end
    end

    // Read data register: loaded by completed reads, zeroed by rejected accesses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_enter_done) begin
            if (w_acc_err) begin
                r_rdata <= '0;
            end else if (w_acc_rd) begin
                r_rdata <= r_mem[w_acc_idx];
            end
        end
    end

    // Storage array; contents survive reset, a reset before DONE drops the write
    always_ff @(posedge clk) begin
        if (!rst && w_enter_done && !w_acc_err && w_acc_wr) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
    end

    // Moore outputs: Ready for the single DONE cycle, Err only alongside it
    always_comb begin
        Ready  = (r_state == S_DONE);
        Err    = (r_state == S_DONE) & r_err;
        R_data = r_rdata;
    end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Testbench for mem_wait_ctrl. Instance A uses RD_LAT=2/WR_LAT=1, instance B
// uses RD_LAT=2/WR_LAT=3 for the reset-during-BUSY scenario.
module tb_mem_wait_ctrl;

    localparam int A_DEPTH = 1024;
    localparam int A_RD    = 2;
    localparam int A_WR    = 1;
    localparam int B_RD    = 2;
    localparam int B_WR    = 3;

    logic        clk = 1'b0;
    logic        a_rst, b_rst;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, a_err, b_ready, b_err;

    int checks = 0;
    int errors = 0;

    // Reference model state for instance A: word-indexed memory plus the
    // read-data register's expected value (unknown when the word never got written).
    logic [31:0] mem_m [int unsigned];
    logic [31:0] last_r;
    bit          last_known;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        bit          err;
        bit          chk_data;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    mem_wait_ctrl #(.DEPTH(A_DEPTH), .RD_LAT(A_RD), .WR_LAT(A_WR)) u_dut_a (
        .clk    (clk),
        .rst    (a_rst),
        .Addr   (a_addr),
        .W_data (a_wdata),
        .MemRd  (a_rd),
        .MemWr  (a_wr),
        .R_data (a_rdata),
        .Ready  (a_ready),
        .Err    (a_err)
    );

    mem_wait_ctrl #(.DEPTH(A_DEPTH), .RD_LAT(B_RD), .WR_LAT(B_WR)) u_dut_b (
        .clk    (clk),
        .rst    (b_rst),
        .Addr   (b_addr),
        .W_data (b_wdata),
        .MemRd  (b_rd),
        .MemWr  (b_wr),
        .R_data (b_rdata),
        .Ready  (b_ready),
        .Err    (b_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata;
        end else begin
            a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata;
        end
    endtask

    // Waits for the capture edge, then watches 8 cycles. The request is
    // removed (and address/data scrambled) one cycle after capture.
    task automatic run_window(input bit sel, output int first_k, output int n_rdy,
                              output bit err_at, output logic [31:0] rd_at,
                              output int stray);
        bit          rdy, e;
        logic [31:0] d;
        first_k = 0; n_rdy = 0; err_at = 1'b0; rd_at = '0; stray = 0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            rdy = sel ? b_ready : a_ready;
            e   = sel ? b_err   : a_err;
            d   = sel ? b_rdata : a_rdata;
            if (rdy) begin
                n_rdy++;
                if (first_k == 0) begin
                    first_k = k; err_at = e; rd_at = d;
                end
            end else if (e) begin
                stray++;
            end
            if (k == 1) drive(sel, 1'b0, 1'b0, $urandom, $urandom);
        end
    endtask

    task automatic do_check(input bit sel, input bit rd, input bit wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int exp_lat, input bit exp_err, input bit chk_data,
                            input logic [31:0] exp_rdata, input string tag);
        int          first_k, n_rdy, stray;
        bit          err_at;
        logic [31:0] rd_at;
        drive(sel, rd, wr, addr, wdata);
        run_window(sel, first_k, n_rdy, err_at, rd_at, stray);
        chk({tag, " latency"}, first_k, exp_lat);
        chk({tag, " pulses"}, n_rdy, (exp_lat == 0) ? 0 : 1);
        chk({tag, " stray Err"}, stray, 0);
        if (exp_lat != 0) begin
            chk({tag, " Err"}, 32'(err_at), 32'(exp_err));
            if (chk_data) chk({tag, " R_data"}, rd_at, exp_rdata);
        end
    endtask

    // Transaction-level model of instance A
    task automatic model_access(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, output int lat, output bit err);
        int unsigned w;
        w   = addr >> 2;
        err = (rd && wr) || (addr[1:0] != 2'b00) || (w >= A_DEPTH);
        lat = wr ? A_WR : A_RD;
        if (err) begin
            last_r = '0; last_known = 1'b1;
        end else if (wr) begin
            mem_m[w] = wdata;
        end else if (mem_m.exists(w)) begin
            last_r = mem_m[w]; last_known = 1'b1;
        end else begin
            last_known = 1'b0;
        end
    endtask

    function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat, input bit err,
                                input bit chk_data, input logic [31:0] rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.err = err; v.chk_data = chk_data; v.rdata = rdata;
        return v;
    endfunction

    initial begin
        int          lat, cnt;
        bit          err, rd, wr, exp_rdy;
        int unsigned op, asel;
        logic [31:0] addr, wdata;

        // Hand-derived vectors for instance A (RD_LAT=2, WR_LAT=1, DEPTH=1024)
        vecs[0]  = mk(0, 1, 32'h10,       32'hDEADBEEF, 1, 0, 1, 32'h0);
        vecs[1]  = mk(1, 0, 32'h10,       32'h0,        2, 0, 1, 32'hDEADBEEF);
        vecs[2]  = mk(0, 1, 32'h13,       32'h0BADF00D, 1, 1, 1, 32'h0);
        vecs[3]  = mk(1, 0, 32'h10,       32'h0,        2, 0, 1, 32'hDEADBEEF);
        vecs[4]  = mk(1, 0, 32'h1000,     32'h0,        2, 1, 1, 32'h0);
        vecs[5]  = mk(1, 1, 32'h10,       32'h55555555, 1, 1, 1, 32'h0);
        vecs[6]  = mk(1, 0, 32'h10,       32'h0,        2, 0, 1, 32'hDEADBEEF);
        vecs[7]  = mk(0, 1, 32'hFFC,      32'h13579BDF, 1, 0, 1, 32'hDEADBEEF);
        vecs[8]  = mk(1, 0, 32'hFFC,      32'h0,        2, 0, 1, 32'h13579BDF);
        vecs[9]  = mk(0, 1, 32'h0,        32'hA5A5A5A5, 1, 0, 1, 32'h13579BDF);
        vecs[10] = mk(1, 0, 32'h0,        32'h0,        2, 0, 1, 32'hA5A5A5A5);
        vecs[11] = mk(1, 0, 32'hFFFFFFFC, 32'h0,        2, 1, 1, 32'h0);
        vecs[12] = mk(0, 0, 32'h10,       32'h0,        0, 0, 0, 32'h0);
        vecs[13] = mk(1, 0, 32'h2,        32'h0,        2, 1, 1, 32'h0);

        // Reset held for 2 edges with a read pending
        a_rst = 1'b1; b_rst = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("reset%0d Ready", i), 32'(a_ready), 32'd0);
            chk($sformatf("reset%0d Err", i), 32'(a_err), 32'd0);
            chk($sformatf("reset%0d R_data", i), a_rdata, 32'h0);
        end
        a_rst = 1'b0; b_rst = 1'b0;
        last_r = '0; last_known = 1'b1;
        begin
            int          fk, nr, st;
            bit          ea;
            logic [31:0] ra;
            run_window(0, fk, nr, ea, ra, st);
            model_access(1'b1, 1'b0, 32'h1000, 32'h0, lat, err);
            chk("post-reset read latency", fk, A_RD);
            chk("post-reset read pulses", nr, 1);
            chk("post-reset read Err", 32'(ea), 32'd1);
            chk("post-reset read R_data", ra, 32'h0);
        end

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rd || vecs[i].wr)
                model_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, err);
            do_check(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                     vecs[i].lat, vecs[i].err, vecs[i].chk_data, vecs[i].rdata,
                     $sformatf("vec%0d", i));
        end

        // Held read on 0x0: one access every RD_LAT+1 cycles, data stable
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            exp_rdy = (k >= A_RD) && (((k - A_RD) % (A_RD + 1)) == 0);
            chk($sformatf("held k%0d Ready", k), 32'(a_ready), 32'(exp_rdy));
            chk($sformatf("held k%0d Err", k), 32'(a_err), 32'd0);
            if (k >= A_RD) chk($sformatf("held k%0d R_data", k), a_rdata, mem_m[0]);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Randomized accesses checked against the model
        for (int n = 0; n < 60; n++) begin
            op   = $urandom_range(0, 9);
            rd   = (op <= 3) || (op == 8);
            wr   = (op >= 4) && (op <= 8);
            asel = $urandom_range(0, 7);
            if (asel < 5)       addr = $urandom_range(0, 7) * 4;
            else if (asel == 5) addr = $urandom_range(0, 7) * 4 + $urandom_range(1, 3);
            else if (asel == 6) addr = 32'h1000 + $urandom_range(0, 255) * 4;
            else                addr = 32'hFFFFFFFC - $urandom_range(0, 3) * 4;
            wdata = $urandom;
            if (rd || wr) begin
                model_access(rd, wr, addr, wdata, lat, err);
                do_check(0, rd, wr, addr, wdata, lat, err, last_known, last_r,
                         $sformatf("rand%0d", n));
            end else begin
                do_check(0, 1'b0, 1'b0, addr, wdata, 0, 1'b0, 1'b0, 32'h0,
                         $sformatf("rand%0d", n));
            end
        end

        // Instance B: reset during the first BUSY cycle of a write
        do_check(1, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, B_WR, 1'b0, 1'b1, 32'h0, "b write");
        do_check(1, 1'b1, 1'b0, 32'h20, 32'h0, B_RD, 1'b0, 1'b1, 32'hCAFEF00D, "b read");
        drive(1, 1'b0, 1'b1, 32'h20, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        chk("b midwr busy Ready", 32'(b_ready), 32'd0);
        b_rst = 1'b1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        b_rst = 1'b0;
        chk("b midwr after rst R_data", b_rdata, 32'h0);
        cnt = 0;
        if (b_ready) cnt++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (b_ready) cnt++;
        end
        chk("b midwr pulses", cnt, 0);
        do_check(1, 1'b1, 1'b0, 32'h20, 32'h0, B_RD, 1'b0, 1'b1, 32'hCAFEF00D, "b reread");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
